// File: rtl/sum_pkg.sv
// Shared constants and types for the summator sequencing stage.
package sum_pkg;

    localparam int SUM_WIDTH = 17;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int cnt_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Sums COUNT stream samples through the external summator and presents the total.
// Optional carry flag output out_ovf is enabled by defining SUM_ACC_OVF_FLAG_EN.
//
// state | meaning
// ACC   | accepting samples, accumulator building the group sum
// HOLD  | group total on out_data, waiting for the consumer
module sum_accumulator
    import sum_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH,
    parameter int COUNT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          add_a,
    output logic [WIDTH-1:0]          add_b,
    input  logic [WIDTH-1:0]          add_res,
    output logic [cnt_w(COUNT)-1:0]   sample_cnt
`ifdef SUM_ACC_OVF_FLAG_EN
    ,
    output logic                      out_ovf
`endif
);

    localparam int            CW   = cnt_w(COUNT);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             accept;
    logic             last_sample;

    assign add_a       = acc_q;
    assign add_b       = in_data;
    assign in_ready    = (state_q == ACC);
    assign out_valid   = (state_q == HOLD);
    assign out_data    = out_data_q;
    assign sample_cnt  = cnt_q;
    assign accept      = in_valid & in_ready;
    assign last_sample = (cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    if (last_sample) begin
                        out_data_d = add_res;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = HOLD;
                    end else begin
                        acc_d = add_res;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef SUM_ACC_OVF_FLAG_EN
    // Carry-out of the summator shows up as a wrapped result smaller than the accumulator.
    logic carry;
    logic sticky_q, sticky_d;
    logic ovf_q, ovf_d;

    assign carry   = (add_res < add_a);
    assign out_ovf = ovf_q;

    always_comb begin
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        if (accept) begin
            if (last_sample) begin
                ovf_d    = sticky_q | carry;
                sticky_d = 1'b0;
            end else begin
                sticky_d = sticky_q | carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end
`endif

endmodule
